// File: rtl/arb_pkg.sv
// Shared types for the 4-requester round-robin arbiter and its combinational picker.
package arb_pkg;

    localparam int N_REQ = 4;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    typedef logic [3:0] onehot4_t;

    // Owner index of a one-hot grant; zero input maps to 0 and is never used that way.
    function automatic logic [1:0] oh_to_idx(input onehot4_t oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request bit searching from ptr upward, mod 4.
module rr_pick4
    import arb_pkg::*;
(
    input  logic     [3:0] req,
    input  logic     [1:0] ptr,
    output onehot4_t       pick
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 2'd0;
        for (int j = 0; j < N_REQ; j++) begin
            idx = ptr + 2'(j);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Registered round-robin arbiter: holds a grant until done, request drop or hold limit,
// always inserting one idle cycle between grants so the downstream encoder never sees a switch.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(HOLD_MAX - 1);

    arb_state_t       state, state_d;
    logic [1:0]       ptr, ptr_d;
    logic [CNT_W-1:0] hold_cnt, cnt_d;
    onehot4_t         gnt_d, pick;
    logic             timeout_d;
    logic [1:0]       owner;
    logic             rel_done, rel_drop, rel_lim, rel;

    rr_pick4 u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick)
    );

    assign owner    = oh_to_idx(gnt);
    assign rel_done = done;
    assign rel_drop = ~|(req & gnt);
    assign rel_lim  = (HOLD_MAX != 0) && (hold_cnt == LIMIT);
    assign rel      = rel_done | rel_drop | rel_lim;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            hold_cnt  <= cnt_d;
            gnt       <= gnt_d;
            gnt_valid <= |gnt_d;
            timeout   <= timeout_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (|req) state_d = GRANT;
            GRANT:   if (rel)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath; a release always lands in a
    // zero-grant cycle, which is what guarantees the bubble between owners.
    always_comb begin
        gnt_d     = gnt;
        ptr_d     = ptr;
        cnt_d     = hold_cnt;
        timeout_d = 1'b0;
        case (state)
            IDLE: begin
                gnt_d = '0;
                if (|req) begin
                    gnt_d = pick;
                    cnt_d = '0;
                end
            end
            GRANT: begin
                if (rel) begin
                    gnt_d     = '0;
                    ptr_d     = owner + 2'd1;
                    timeout_d = rel_lim & ~rel_done & ~rel_drop;
                end else if (hold_cnt != '1) begin
                    cnt_d = hold_cnt + 1'b1;
                end
            end
            default: gnt_d = '0;
        endcase
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed-vector bench for rr_arbiter4 with a queue scoreboard and a separate monitor.
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic       timeout;

    typedef struct {
        logic [3:0] gnt;
        logic       to;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vec   = 0;

    rr_arbiter4 #(.HOLD_MAX(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [3:0] act, input logic [3:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s vec%0d: got %b expected %b", name, id, act, want);
        end
    endtask

    // Inputs held for one cycle; expected outputs are those visible after the following edge.
    task automatic step(input logic r, input logic [3:0] q, input logic d,
                        input logic [3:0] eg, input logic et);
        exp_t e;
        rst  = r;
        req  = q;
        done = d;
        e.gnt = eg;
        e.to  = et;
        e.id  = vec++;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: every sampled cycle with a pending expectation is checked against it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gnt",       e.id, gnt,             e.gnt);
                chk("gnt_valid", e.id, {3'b0, gnt_valid}, {3'b0, |e.gnt});
                chk("timeout",   e.id, {3'b0, timeout},   {3'b0, e.to});
                chk("onehot",    e.id, {3'b0, $countones(gnt) <= 1}, 4'd1);
                chk("to_idle",   e.id, {3'b0, !timeout || gnt == 4'b0}, 4'd1);
            end
        end
    end

    initial begin
        // reset with all requests pending
        step(1, 4'b1111, 0, 4'b0000, 0);
        step(1, 4'b1111, 0, 4'b0000, 0);
        step(0, 4'b1111, 0, 4'b0001, 0);
        // fairness: done every grant cycle
        step(0, 4'b1111, 1, 4'b0000, 0);
        step(0, 4'b1111, 0, 4'b0010, 0);
        step(0, 4'b1111, 1, 4'b0000, 0);
        step(0, 4'b1111, 0, 4'b0100, 0);
        step(0, 4'b1111, 1, 4'b0000, 0);
        step(0, 4'b1111, 0, 4'b1000, 0);
        step(0, 4'b1111, 1, 4'b0000, 0);
        step(0, 4'b1111, 0, 4'b0001, 0);
        // owner 0 drops its request; single request from 2, then search starts at 3
        step(0, 4'b0100, 0, 4'b0000, 0);
        step(0, 4'b0100, 0, 4'b0100, 0);
        step(0, 4'b0100, 1, 4'b0000, 0);
        step(0, 4'b1001, 0, 4'b1000, 0);
        step(0, 4'b1001, 0, 4'b1000, 0);
        // reset mid-grant returns ptr to 0
        step(1, 4'b1111, 0, 4'b0000, 0);
        step(0, 4'b1111, 0, 4'b0001, 0);
        step(0, 4'b1111, 1, 4'b0000, 0);
        // hold limit: 8 grant cycles, timeout bubble, regrant
        for (int i = 0; i < 8; i++) step(0, 4'b0010, 0, 4'b0010, 0);
        step(0, 4'b0010, 0, 4'b0000, 1);
        step(0, 4'b0010, 0, 4'b0010, 0);
        // done on the 8th grant cycle: normal release, no timeout
        for (int i = 0; i < 7; i++) step(0, 4'b0010, 0, 4'b0010, 0);
        step(0, 4'b0010, 1, 4'b0000, 0);
        step(0, 4'b0010, 0, 4'b0010, 0);
        // request drop mid-grant, then idle
        step(0, 4'b0010, 0, 4'b0010, 0);
        step(0, 4'b0000, 0, 4'b0000, 0);
        step(0, 4'b0000, 0, 4'b0000, 0);
        step(0, 4'b0000, 0, 4'b0000, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
